// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal oversampling ratios,
// parity-type codes and the 3-sample majority vote.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int unsigned PRESC_X8  = 32'd8;
  localparam int unsigned PRESC_X16 = 32'd16;
  localparam int unsigned PRESC_X32 = 32'd32;
  localparam int unsigned PRESC_MIN = PRESC_X8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receiver-side bundle: serial line plus frame configuration in, parallel word
// and status pulses out.
interface uart_rx_core_if #(
  parameter int DATA_LENGTH = 8,
  parameter int PRESC_W     = 6
);
  logic                   RX_IN;
  logic [PRESC_W-1:0]     PRESCALE;
  logic                   PAR_EN;
  logic                   PAR_TYP;
  logic [DATA_LENGTH-1:0] P_DATA;
  logic                   DATA_VALID;
  logic                   PAR_ERR;
  logic                   STP_ERR;

  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit timing for the UART receiver: oversampling edge counter, bit counter and
// a 3-point majority vote around mid-bit; o_sample_done marks the last edge of a bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W   = 6,
  parameter int BIT_CNT_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_active,
  input  logic                 i_rx,
  input  logic [PRESC_W-1:0]   i_presc,
  output logic [BIT_CNT_W-1:0] o_bit_cnt,
  output logic                 o_bit,
  output logic                 o_sample_done
);

  logic [PRESC_W-1:0]   r_edge_cnt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [2:0]           r_samples;
  logic [PRESC_W-1:0]   w_half;
  logic [PRESC_W-1:0]   w_last;

  assign w_half = i_presc >> 1;
  assign w_last = i_presc - PRESC_W'(1);

  // Edge/bit counting and mid-bit sample capture; counters park at 0 while idle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_samples  <= 3'b000;
    end else if (!i_active) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_samples  <= 3'b000;
    end else begin
      if (r_edge_cnt == w_last) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
      end else begin
        r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
      end
      if (r_edge_cnt == w_half - PRESC_W'(1)) r_samples[0] <= i_rx;
      if (r_edge_cnt == w_half)               r_samples[1] <= i_rx;
      if (r_edge_cnt == w_half + PRESC_W'(1)) r_samples[2] <= i_rx;
    end
  end

  assign o_bit_cnt     = r_bit_cnt;
  assign o_bit         = majority3(r_samples);
  assign o_sample_done = i_active && (r_edge_cnt == w_last);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver top: frame FSM, LSB-first deserialiser, parity/stop checking and
// registered word/status outputs. Bit timing comes from uart_rx_sampler.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_LENGTH = 8,
  parameter int PRESC_W     = 6
) (
  input  logic           CLK,
  input  logic           RST,
  uart_rx_core_if.slave  bus
);

  localparam int                   BIT_CNT_W     = $clog2(DATA_LENGTH + 4);
  localparam logic [PRESC_W-1:0]   PRESC_FLOOR   = PRESC_W'(PRESC_MIN);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_LENGTH);

  rx_state_e              r_state;
  logic [PRESC_W-1:0]     r_presc;
  logic                   r_par_en;
  logic                   r_par_typ;
  logic                   r_par_fail;
  logic [DATA_LENGTH-1:0] r_shift;
  logic [DATA_LENGTH-1:0] r_p_data;
  logic                   r_data_valid;
  logic                   r_par_err;
  logic                   r_stp_err;

  logic [PRESC_W-1:0]     w_presc_eff;
  logic                   w_active;
  logic                   w_bit;
  logic                   w_done;
  logic                   w_exp_par;
  logic [BIT_CNT_W-1:0]   w_bit_cnt;

  // Out-of-contract small ratios are clamped so the counters always have room to wrap.
  assign w_presc_eff = (bus.PRESCALE < PRESC_FLOOR) ? PRESC_FLOOR : bus.PRESCALE;
  assign w_active    = (r_state != ST_IDLE);
  assign w_exp_par   = (r_par_typ == PAR_ODD) ? ~^r_shift : ^r_shift;

  uart_rx_sampler #(
    .PRESC_W   (PRESC_W),
    .BIT_CNT_W (BIT_CNT_W)
  ) u_sampler (
    .CLK           (CLK),
    .RST           (RST),
    .i_active      (w_active),
    .i_rx          (bus.RX_IN),
    .i_presc       (r_presc),
    .o_bit_cnt     (w_bit_cnt),
    .o_bit         (w_bit),
    .o_sample_done (w_done)
  );

  // Frame FSM with shift register, parity tracking and registered status pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_presc      <= PRESC_FLOOR;
      r_par_en     <= 1'b0;
      r_par_typ    <= PAR_EVEN;
      r_par_fail   <= 1'b0;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!bus.RX_IN) begin
            r_state    <= ST_START;
            r_presc    <= w_presc_eff;
            r_par_en   <= bus.PAR_EN;
            r_par_typ  <= bus.PAR_TYP;
            r_par_fail <= 1'b0;
          end
        end
        ST_START: begin
          if (w_done) begin
            r_state <= w_bit ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_done) begin
            r_shift <= {w_bit, r_shift[DATA_LENGTH-1:1]};
            if (w_bit_cnt == LAST_DATA_BIT) begin
              r_state <= r_par_en ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (w_done) begin
            r_par_fail <= (w_bit != w_exp_par);
            r_state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_done) begin
            r_stp_err <= ~w_bit;
            r_par_err <= r_par_fail;
            if (w_bit && !r_par_fail) begin
              r_p_data     <= r_shift;
              r_data_valid <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.P_DATA     = r_p_data;
  assign bus.DATA_VALID = r_data_valid;
  assign bus.PAR_ERR    = r_par_err;
  assign bus.STP_ERR    = r_stp_err;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames push expected events,
// a negedge monitor pops and compares whenever the receiver reports something.
module tb_uart_rx_core;
  import uart_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_core_if #(.DATA_LENGTH(8), .PRESC_W(6)) bus ();

  uart_rx_core #(.DATA_LENGTH(8), .PRESC_W(6)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  typedef struct packed {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push(input logic dv, input logic pe, input logic se, input logic [7:0] d);
    exp_t e;
    e.dv = dv; e.pe = pe; e.se = se; e.data = d;
    exp_q.push_back(e);
  endtask

  // monitor: every reported event must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got dv=%b pe=%b se=%b data=%h want no event",
                 bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, bus.P_DATA);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_flags", {29'd0, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR},
              {29'd0, mon_e.dv, mon_e.pe, mon_e.se});
        check("event_data", {24'd0, bus.P_DATA}, {24'd0, mon_e.data});
      end
    end
  end

  task automatic drive_bit(input logic b, input int n);
    bus.RX_IN = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                            input logic pbit, input logic stopb, input int flip_idx);
    bus.PRESCALE = 6'(p);
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) begin
      if (i == flip_idx) begin
        drive_bit(d[i], p / 2 + 1);
        drive_bit(~d[i], 1);
        drive_bit(d[i], p - p / 2 - 2);
      end else begin
        drive_bit(d[i], p);
      end
    end
    if (pen) drive_bit(pbit, p);
    drive_bit(stopb, p);
    bus.RX_IN = 1'b1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic check_quiet(input string name, input logic [7:0] pdata);
    check({name, "_pdata"}, {24'd0, bus.P_DATA}, {24'd0, pdata});
    check({name, "_flags"}, {29'd0, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}, 32'd0);
  endtask

  initial begin
    bus.RX_IN    = 1'b1;
    bus.PRESCALE = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = PAR_EVEN;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset", 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);

    // 1) P=8, no parity, 0xA5; DATA_VALID exactly one cycle after stop edge P-1
    push(1'b1, 1'b0, 1'b0, 8'hA5);
    send_frame(8'hA5, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    @(negedge clk);
    check("t1_dv_not_early", {31'd0, bus.DATA_VALID}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t1_dv_latency", {31'd0, bus.DATA_VALID}, 32'd1);
    idle(4);
    drain("t1_drain");

    // 2) P=16 even parity, 0x3C has four ones -> parity bit 0 good, 1 bad
    push(1'b1, 1'b0, 1'b0, 8'h3C);
    send_frame(8'h3C, 16, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1);
    idle(4);
    push(1'b0, 1'b1, 1'b0, 8'h3C);
    send_frame(8'h3C, 16, 1'b1, PAR_EVEN, 1'b1, 1'b1, -1);
    idle(4);
    drain("t2_drain");

    // 3) P=32 odd parity, 0x00 with correct parity 1, stop driven 0
    push(1'b0, 1'b0, 1'b1, 8'h3C);
    send_frame(8'h00, 32, 1'b1, PAR_ODD, 1'b1, 1'b0, -1);
    idle(4);
    // both errors: 0x01 even needs parity 1, send 0, stop 0
    push(1'b0, 1'b1, 1'b1, 8'h3C);
    send_frame(8'h01, 8, 1'b1, PAR_EVEN, 1'b0, 1'b0, -1);
    idle(4);
    drain("t3_drain");

    // 4) 2-cycle low glitch on idle line at P=16
    bus.PRESCALE = 6'd16;
    bus.PAR_EN   = 1'b0;
    drive_bit(1'b0, 2);
    idle(40);
    @(negedge clk);
    check_quiet("t4_glitch", 8'h3C);

    // 5) single-sample flip at edge P/2 of data bit 1 of 0x5A
    push(1'b1, 1'b0, 1'b0, 8'h5A);
    send_frame(8'h5A, 16, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1);
    idle(4);
    push(1'b1, 1'b0, 1'b0, 8'h81);
    send_frame(8'h81, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 7);
    idle(4);
    drain("t5_drain");

    // 6) reset in the middle of the data bits, then 0xFF back-to-back twice
    bus.PRESCALE = 6'd8;
    bus.PAR_EN   = 1'b0;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b1, 8);
    rst_n = 1'b0;
    @(negedge clk);
    check_quiet("t6_in_reset", 8'h00);
    bus.RX_IN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    @(negedge clk);
    check_quiet("t6_after_reset", 8'h00);
    push(1'b1, 1'b0, 1'b0, 8'hFF);
    push(1'b1, 1'b0, 1'b0, 8'hFF);
    send_frame(8'hFF, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    send_frame(8'hFF, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    idle(4);
    drain("t6_drain");

    // line held low for two receiver frames (2*81-1 cycles): two stop errors, no lockup
    push(1'b0, 1'b0, 1'b1, 8'hFF);
    push(1'b0, 1'b0, 1'b1, 8'hFF);
    drive_bit(1'b0, 161);
    idle(20);
    drain("t7_drain");
    push(1'b1, 1'b0, 1'b0, 8'h96);
    send_frame(8'h96, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    idle(4);
    drain("t7_recover");

    idle(10);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
